// File: rtl/ball_motion_pkg.sv
// Shared constants and types for the ball_motion position engine.
package ball_pkg;

  localparam int unsigned H_ACTIVE_DEF  = 640;
  localparam int unsigned V_ACTIVE_DEF  = 480;
  localparam int unsigned BALL_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    StIdle,
    StStepX,
    StStepY,
    StCommit
  } state_e;

  // 0 = moving toward increasing coordinates, 1 = toward decreasing.
  typedef logic dir_t;
  localparam dir_t DIR_POS = 1'b0;
  localparam dir_t DIR_NEG = 1'b1;

endpackage

// File: rtl/ball_motion_axis_step.sv
// Combinational clamp-and-reflect for one axis; shared between X and Y by the FSM.
module axis_step
  import ball_pkg::*;
#(
  parameter int unsigned POS_W = 10
) (
  input  logic [POS_W-1:0] pos,
  input  dir_t             dir,
  input  logic [3:0]       step,
  input  logic [POS_W-1:0] max,
  output logic [POS_W-1:0] next_pos,
  output dir_t             next_dir,
  output logic             hit
);

  logic [POS_W:0] pos_ext;
  logic [POS_W:0] step_ext;
  logic [POS_W:0] max_ext;
  logic [POS_W:0] sum;

  // One extra bit keeps pos+step from wrapping before the compare.
  assign pos_ext  = {1'b0, pos};
  assign step_ext = {{(POS_W - 3){1'b0}}, step};
  assign max_ext  = {1'b0, max};
  assign sum      = pos_ext + step_ext;

  always_comb begin
    next_pos = pos;
    next_dir = dir;
    hit      = 1'b0;
    if (dir == DIR_POS) begin
      if (sum >= max_ext) begin
        next_pos = max;
        next_dir = DIR_NEG;
        hit      = 1'b1;
      end else begin
        next_pos = sum[POS_W-1:0];
      end
    end else begin
      if (pos_ext <= step_ext) begin
        next_pos = '0;
        next_dir = DIR_POS;
        hit      = 1'b1;
      end else begin
        next_pos = pos - step_ext[POS_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball position engine: IDLE -> STEP_X -> STEP_Y -> COMMIT on each frame tick.
// Optional corner pulse / double colour advance under macro BALL_CORNER_DETECT_EN.
module ball_motion
  import ball_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned BALL_SIZE = BALL_SIZE_DEF,
  parameter int unsigned POS_W     = 10,
  parameter int unsigned INIT_X    = 100,
  parameter int unsigned INIT_Y    = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             pause,
  input  logic [2:0]       speed,
  output logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] ball_y,
  output logic [2:0]       color_idx,
  output logic             bounce,
  output logic             corner,
  output logic             busy
);

  localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACTIVE - BALL_SIZE);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACTIVE - BALL_SIZE);

  state_e           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  dir_t             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [POS_W-1:0] shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
  dir_t             shadow_dx_q, shadow_dx_d, shadow_dy_q, shadow_dy_d;
  logic             hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  logic [2:0]       color_q, color_d;
  logic             bounce_q, bounce_d;
  logic             corner_q, corner_d;

  logic [POS_W-1:0] axis_pos, axis_max, axis_next_pos;
  dir_t             axis_dir, axis_next_dir;
  logic             axis_hit;

  // Single axis unit: Y operands in STEP_Y, X operands otherwise.
  assign axis_pos = (state_q == StStepY) ? y_q : x_q;
  assign axis_dir = (state_q == StStepY) ? dir_y_q : dir_x_q;
  assign axis_max = (state_q == StStepY) ? Y_MAX : X_MAX;

  axis_step #(
    .POS_W (POS_W)
  ) u_axis_step (
    .pos      (axis_pos),
    .dir      (axis_dir),
    .step     (step_q),
    .max      (axis_max),
    .next_pos (axis_next_pos),
    .next_dir (axis_next_dir),
    .hit      (axis_hit)
  );

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    shadow_x_d  = shadow_x_q;
    shadow_y_d  = shadow_y_q;
    shadow_dx_d = shadow_dx_q;
    shadow_dy_d = shadow_dy_q;
    hit_x_d     = hit_x_q;
    hit_y_d     = hit_y_q;
    color_d     = color_q;
    bounce_d    = 1'b0;
    corner_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_tick && !pause) begin
          step_d  = {1'b0, speed} + 4'd1;
          state_d = StStepX;
        end
      end
      StStepX: begin
        shadow_x_d  = axis_next_pos;
        shadow_dx_d = axis_next_dir;
        hit_x_d     = axis_hit;
        state_d     = StStepY;
      end
      StStepY: begin
        shadow_y_d  = axis_next_pos;
        shadow_dy_d = axis_next_dir;
        hit_y_d     = axis_hit;
        state_d     = StCommit;
      end
      StCommit: begin
        x_d     = shadow_x_q;
        y_d     = shadow_y_q;
        dir_x_d = shadow_dx_q;
        dir_y_d = shadow_dy_q;
        if (hit_x_q || hit_y_q) begin
          bounce_d = 1'b1;
`ifdef BALL_CORNER_DETECT_EN
          corner_d = hit_x_q & hit_y_q;
          color_d  = color_q + ((hit_x_q & hit_y_q) ? 3'd2 : 3'd1);
`else
          color_d  = color_q + 3'd1;
`endif
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      step_q      <= 4'd1;
      x_q         <= POS_W'(INIT_X);
      y_q         <= POS_W'(INIT_Y);
      dir_x_q     <= DIR_POS;
      dir_y_q     <= DIR_POS;
      shadow_x_q  <= '0;
      shadow_y_q  <= '0;
      shadow_dx_q <= DIR_POS;
      shadow_dy_q <= DIR_POS;
      hit_x_q     <= 1'b0;
      hit_y_q     <= 1'b0;
      color_q     <= 3'd0;
      bounce_q    <= 1'b0;
      corner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      shadow_x_q  <= shadow_x_d;
      shadow_y_q  <= shadow_y_d;
      shadow_dx_q <= shadow_dx_d;
      shadow_dy_q <= shadow_dy_d;
      hit_x_q     <= hit_x_d;
      hit_y_q     <= hit_y_d;
      color_q     <= color_d;
      bounce_q    <= bounce_d;
      corner_q    <= corner_d;
    end
  end

  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign color_idx = color_q;
  assign bounce    = bounce_q;
  assign corner    = corner_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ball_motion.sv
// Directed table-driven bench for ball_motion plus hand-written multi-cycle sequences.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] speed = 3'd0;
  logic [9:0] ball_x, ball_y;
  logic [2:0] color_idx;
  logic       bounce, corner, busy;

  logic       c_reset = 1'b1;
  logic       c_tick = 1'b0;
  logic [9:0] c_x, c_y;
  logic [2:0] c_color;
  logic       c_bounce, c_corner, c_busy;

  always #5 clk = ~clk;

  ball_motion dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .pause      (pause),
    .speed      (speed),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .color_idx  (color_idx),
    .bounce     (bounce),
    .corner     (corner),
    .busy       (busy)
  );

  ball_motion #(
    .INIT_X (604),
    .INIT_Y (444)
  ) dut_corner (
    .clk        (clk),
    .reset      (c_reset),
    .frame_tick (c_tick),
    .pause      (1'b0),
    .speed      (speed),
    .ball_x     (c_x),
    .ball_y     (c_y),
    .color_idx  (c_color),
    .bounce     (c_bounce),
    .corner     (c_corner),
    .busy       (c_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit do_reset;
    bit pause;
    int speed;
    int ticks;
    int x;
    int y;
    int color;
    int bounces;
    int busy_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One tick, then run until idle; reports busy cycles and bounce pulses seen.
  task automatic do_update(output int busy_cyc, output int bounces);
    int guard;
    busy_cyc = 0;
    bounces  = 0;
    guard    = 0;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    while (busy && guard < 10) begin
      busy_cyc++;
      if (bounce) bounces++;
      cyc();
      guard++;
    end
    if (guard >= 10) chk("update_timeout", guard, 0);
    if (bounce) bounces++;
  endtask

  initial begin
    int bc, bn, max_busy, tot_bn;

    //            rst pause spd ticks   x    y  col bnc busy
    vecs[0] = '{1'b1, 1'b0, 0,   0,  100,  50,  0,  0,  0};
    vecs[1] = '{1'b0, 1'b0, 3,   1,  104,  54,  0,  0,  3};
    vecs[2] = '{1'b1, 1'b0, 7,  50,  500, 448,  1,  1,  3};
    vecs[3] = '{1'b0, 1'b0, 7,  14,  608, 336,  2,  1,  3};
    vecs[4] = '{1'b0, 1'b1, 7,   5,  608, 336,  2,  0,  0};
    vecs[5] = '{1'b0, 1'b0, 0,   1,  607, 335,  2,  0,  3};

    cyc();
    cyc();
    reset = 1'b0;
    c_reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_reset) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
      end
      pause = vecs[i].pause;
      speed = 3'(vecs[i].speed);
      max_busy = 0;
      tot_bn = 0;
      for (int t = 0; t < vecs[i].ticks; t++) begin
        do_update(bc, bn);
        if (bc > max_busy) max_busy = bc;
        tot_bn += bn;
      end
      chk($sformatf("v%0d_x", i), int'(ball_x), vecs[i].x);
      chk($sformatf("v%0d_y", i), int'(ball_y), vecs[i].y);
      chk($sformatf("v%0d_color", i), int'(color_idx), vecs[i].color);
      chk($sformatf("v%0d_bounces", i), tot_bn, vecs[i].bounces);
      chk($sformatf("v%0d_busy_cycles", i), max_busy, vecs[i].busy_cyc);
      if (vecs[i].ticks == 0) begin
        chk("reset_bounce", int'(bounce), 0);
        chk("reset_busy", int'(busy), 0);
      end
    end
    pause = 1'b0;

    // Reset while in STEP_Y aborts the update.
    speed = 3'd3;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_stepy_x", int'(ball_x), 100);
    chk("rst_stepy_y", int'(ball_y), 50);
    chk("rst_stepy_color", int'(color_idx), 0);
    chk("rst_stepy_busy", int'(busy), 0);
    cyc();
    cyc();
    cyc();
    chk("rst_stepy_after_x", int'(ball_x), 100);
    chk("rst_stepy_after_busy", int'(busy), 0);

    // Ticks on cycles 0 and 2, speed changed mid-update: one update of +4.
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    speed = 3'd7;
    cyc();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("mid_update_x_stable", int'(ball_x), 100);
    cyc();
    cyc();
    chk("double_tick_busy", int'(busy), 0);
    chk("double_tick_x", int'(ball_x), 104);
    chk("double_tick_y", int'(ball_y), 54);
    cyc();
    cyc();
    chk("double_tick_x_hold", int'(ball_x), 104);

    // Simultaneous X+Y hit on the corner instance.
    speed = 3'd7;
    c_tick = 1'b1;
    cyc();
    c_tick = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("corner_x", int'(c_x), 608);
    chk("corner_y", int'(c_y), 448);
    chk("corner_bounce", int'(c_bounce), 1);
`ifdef BALL_CORNER_DETECT_EN
    chk("corner_flag", int'(c_corner), 1);
    chk("corner_color", int'(c_color), 2);
`else
    chk("corner_flag", int'(c_corner), 0);
    chk("corner_color", int'(c_color), 1);
`endif
    cyc();
    chk("corner_bounce_pulse", int'(c_bounce), 0);
    chk("corner_flag_pulse", int'(c_corner), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
